// File: rtl/bcd_seg_display.sv
// Registered 3-digit BCD to active-low 7-segment display stage.
// Captures a packed BCD word on load and drives HEX2..HEX0 with optional
// leading-zero blanking, whole-display blinking and invalid-digit flagging.
module bcd_seg_display #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        bcd_err,
    output logic        shown
);

    localparam int unsigned HALF   = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [3:0]       dig2;
    logic [3:0]       dig1;
    logic [3:0]       dig0;
    logic [CNT_W-1:0] presc;
    logic             phase_hidden;
    logic [6:0]       seg2_c;
    logic [6:0]       seg1_c;
    logic [6:0]       seg0_c;

    // Active-low segment pattern for one BCD digit; A..F show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Capture the BCD word and flag any nibble above 9.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig2    <= 4'd0;
            dig1    <= 4'd0;
            dig0    <= 4'd0;
            shown   <= 1'b0;
            bcd_err <= 1'b0;
        end else if (load) begin
            dig2    <= bcd_in[11:8];
            dig1    <= bcd_in[7:4];
            dig0    <= bcd_in[3:0];
            shown   <= 1'b1;
            bcd_err <= (bcd_in[11:8] > 4'd9) || (bcd_in[7:4] > 4'd9) ||
                       (bcd_in[3:0] > 4'd9);
        end
    end

    // Blink half-period prescaler; a load or blink disable restarts a visible half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            phase_hidden <= 1'b0;
        end else if (load || !shown || !blink_en) begin
            presc        <= '0;
            phase_hidden <= 1'b0;
        end else if (presc == CNT_LAST) begin
            presc        <= '0;
            phase_hidden <= ~phase_hidden;
        end else begin
            presc        <= presc + CNT_W'(1);
        end
    end

    // Next display pattern: decode, then blank leading zeros, then blink/off override.
    always_comb begin
        seg2_c = seg_decode(dig2);
        seg1_c = seg_decode(dig1);
        seg0_c = seg_decode(dig0);
        if (blank_lz && (dig2 == 4'd0)) begin
            seg2_c = SEG_OFF;
            if (dig1 == 4'd0) begin
                seg1_c = SEG_OFF;
            end
        end
        if (!shown || (blink_en && phase_hidden)) begin
            seg2_c = SEG_OFF;
            seg1_c = SEG_OFF;
            seg0_c = SEG_OFF;
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex2 <= SEG_OFF;
            hex1 <= SEG_OFF;
            hex0 <= SEG_OFF;
        end else begin
            hex2 <= seg2_c;
            hex1 <= seg1_c;
            hex0 <= seg0_c;
        end
    end

endmodule
